// File: rtl/mult32_seq_pkg.sv
// Shared definitions for the iterative shift-add multiplier: widths and FSM state encodings.
package mult32_seq_pkg;
  localparam int DATA_WIDTH   = 32;
  localparam int DOUBLE_WIDTH = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;
endpackage

// File: rtl/mult32_add_shift.sv
// One combinational shift-add step: gate the multiplicand by P[0], add into the upper half,
// then shift right with the adder carry entering the top bit.
module mult32_add_shift
  import mult32_seq_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic [2*WIDTH-1:0] p,
  input  logic [WIDTH-1:0]   a,
  output logic [2*WIDTH-1:0] p_next
);
  logic [WIDTH-1:0] pp;
  logic [WIDTH:0]   sum;

  assign pp     = a & {WIDTH{p[0]}};
  assign sum    = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, pp};
  assign p_next = {sum, p[WIDTH-1:1]};
endmodule

// File: rtl/mult32_seq.sv
// Iterative unsigned multiplier, one product bit per cycle, result held in HI/LO.
// state    | meaning
// MUL_IDLE | waiting for START
// MUL_RUN  | shifting/adding, count = step index 0..WIDTH-1
// MUL_DONE | one-cycle completion pulse; START here is accepted as in IDLE
module mult32_seq
  import mult32_seq_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             ZERO
);
  localparam int CW = $clog2(WIDTH);

  mul_state_t         state, state_nxt;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] p, p_next;
  logic [WIDTH-1:0]   a_reg;
  logic               accept, zero_op, last_step;

  assign accept    = START && (state != MUL_RUN);
  assign zero_op   = (A == '0) || (B == '0);
  assign last_step = (state == MUL_RUN) && (count == CW'(WIDTH - 1));

  mult32_add_shift #(.WIDTH(WIDTH)) u_step (
    .p      (p),
    .a      (a_reg),
    .p_next (p_next)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= MUL_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = MUL_IDLE;
    case (state)
      MUL_IDLE, MUL_DONE: begin
        if (START) state_nxt = zero_op ? MUL_DONE : MUL_RUN;
        else       state_nxt = MUL_IDLE;
      end
      MUL_RUN:  state_nxt = last_step ? MUL_DONE : MUL_RUN;
      default:  state_nxt = MUL_IDLE;
    endcase
  end

  always_comb begin
    BUSY = 1'b0;
    DONE = 1'b0;
    case (state)
      MUL_RUN:  BUSY = 1'b1;
      MUL_DONE: DONE = 1'b1;
      default: ;
    endcase
  end

  // The final step bypasses P and lands directly in HI/LO so DONE coincides with the result.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p     <= '0;
      a_reg <= '0;
      count <= '0;
      HI    <= '0;
      LO    <= '0;
      ZERO  <= 1'b1;
    end else if (accept) begin
      a_reg <= A;
      count <= '0;
      if (zero_op) begin
        HI   <= '0;
        LO   <= '0;
        ZERO <= 1'b1;
      end else begin
        p <= {{WIDTH{1'b0}}, B};
      end
    end else if (state == MUL_RUN) begin
      p     <= p_next;
      count <= count + CW'(1);
      if (last_step) begin
        HI   <= p_next[2*WIDTH-1:WIDTH];
        LO   <= p_next[WIDTH-1:0];
        ZERO <= ~|(p_next[2*WIDTH-1:WIDTH] | p_next[WIDTH-1:0]);
      end
    end
  end
endmodule

// File: tb/tb_mult32_seq.sv
// Scoreboard bench for mult32_seq: directed operands with hand-computed products.
module tb_mult32_seq;
  logic        CLK = 1'b0;
  logic        RST, START;
  logic [31:0] A, B;
  logic        BUSY, DONE, ZERO;
  logic [31:0] HI, LO;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] sb[$];

  mult32_seq dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .HI(HI), .LO(LO), .ZERO(ZERO)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every DONE pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (RST === 1'b0 && DONE === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got DONE=1 with HI=%h LO=%h, expected no DONE", HI, LO);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        check("hi", 64'(HI), 64'(e[63:32]));
        check("lo", 64'(LO), 64'(e[31:0]));
        check("zero", 64'(ZERO), 64'(e == 64'd0));
      end
    end
  end

  // Called on a negedge; START is accepted at the following posedge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    A = a;
    B = b;
    START = 1'b1;
    sb.push_back(exp);
  endtask

  // Counts negedges after the accepting edge until DONE; optional mid-run START re-pulse
  // and optional check that the previous result is still held mid-run.
  task automatic wait_done(input string name, input int exp_cyc, input int exp_busy,
                           input int pulse_at, input bit held_chk, input logic [63:0] held);
    int cyc = 0;
    int busy = 0;
    bit seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge CLK);
      cyc++;
      if (cyc == 1) START = 1'b0;
      if (pulse_at != 0 && cyc == pulse_at) begin
        START = 1'b1; A = 32'd5; B = 32'd5;
      end
      if (pulse_at != 0 && cyc == pulse_at + 1) START = 1'b0;
      if (held_chk && cyc == 16) check({name, "_held"}, {HI, LO}, held);
      if (BUSY) busy++;
      if (DONE) seen = 1'b1;
    end
    check({name, "_latency"}, 64'(cyc), 64'(exp_cyc));
    check({name, "_busy_cycles"}, 64'(busy), 64'(exp_busy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; START = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge CLK);
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_done", 64'(DONE), 64'd0);
    check("rst_hilo", {HI, LO}, 64'd0);
    check("rst_zero", 64'(ZERO), 64'd1);
    RST = 1'b0;
    @(negedge CLK);

    issue(32'd3, 32'd5, 64'd15);
    wait_done("t1", 33, 32, 0, 1'b0, 64'd0);
    @(negedge CLK);

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    wait_done("t2", 33, 32, 0, 1'b0, 64'd0);
    @(negedge CLK);

    issue(32'h1234_5678, 32'd0, 64'd0);
    wait_done("t3a", 1, 0, 0, 1'b0, 64'd0);
    @(negedge CLK);
    issue(32'd0, 32'd5, 64'd0);
    wait_done("t3b", 1, 0, 0, 1'b0, 64'd0);
    @(negedge CLK);

    issue(32'h0000_FFFF, 32'h0001_0001, 64'h0000_0000_FFFF_FFFF);
    wait_done("t4", 33, 32, 5, 1'b0, 64'd0);
    repeat (5) @(negedge CLK);
    check("t4_idle_busy", 64'(BUSY), 64'd0);

    // Reset mid-run: outputs drop immediately and the pending product is discarded.
    issue(32'd100, 32'd200, 64'd20000);
    @(negedge CLK);
    START = 1'b0;
    repeat (9) @(negedge CLK);
    check("t5_busy_before", 64'(BUSY), 64'd1);
    RST = 1'b1;
    #1;
    check("t5_rst_busy", 64'(BUSY), 64'd0);
    check("t5_rst_done", 64'(DONE), 64'd0);
    check("t5_rst_hilo", {HI, LO}, 64'd0);
    check("t5_rst_zero", 64'(ZERO), 64'd1);
    sb.delete();
    @(negedge CLK);
    RST = 1'b0;
    repeat (40) @(negedge CLK);
    issue(32'd1000, 32'd1000, 64'd1_000_000);
    wait_done("t5_after", 33, 32, 0, 1'b0, 64'd0);
    @(negedge CLK);

    issue(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
    wait_done("t6a", 33, 32, 0, 1'b0, 64'd0);
    issue(32'd7, 32'd6, 64'd42);
    wait_done("t6b", 33, 32, 0, 1'b1, 64'h0000_0001_0000_0000);
    @(negedge CLK);

    issue(32'h8000_0001, 32'd3, 64'h0000_0001_8000_0003);
    wait_done("t7", 33, 32, 0, 1'b0, 64'd0);
    repeat (3) @(negedge CLK);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
